// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Counter must hold 0..ITER without wrapping.
    function automatic int cnt_width(input int iter);
        return $clog2(iter + 1);
    endfunction

    // Partial remainder carries one extra bit so the shifted value never overflows.
    function automatic int prem_width(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift in a bit, subtract the divisor if it fits.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   p_i,
    input  logic             b_i,
    input  logic [WIDTH-1:0] den_i,
    output logic [WIDTH:0]   p_o,
    output logic             q_o
);

    logic [WIDTH:0] t;
    logic [WIDTH:0] d;
    logic           unused_p_msb;

    // P < den holds between iterations, so its top bit is always zero.
    assign unused_p_msb = p_i[WIDTH];

    always_comb begin
        t   = {p_i[WIDTH-1:0], b_i};
        d   = {1'b0, den_i};
        q_o = (t >= d);
        p_o = q_o ? (t - d) : t;
    end

endmodule

// File: rtl/seq_fixed_divider.sv
// Multi-cycle unsigned fixed-point divider: WIDTH integer plus FRAC_BITS fraction quotient bits.
module seq_fixed_divider
    import div_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int FRAC_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     num,
    input  logic [WIDTH-1:0]     den,
    output logic                 ready,
    output logic                 done,
    output logic [WIDTH-1:0]     quot,
    output logic [WIDTH-1:0]     rem,
    output logic [FRAC_BITS-1:0] frac,
    output logic                 div_zero
);

    localparam int ITER = WIDTH + FRAC_BITS;
    localparam int CW   = cnt_width(ITER);
    localparam int PW   = prem_width(WIDTH);

    localparam logic [CW-1:0] LAST_INT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST     = CW'(ITER - 1);

    typedef logic [PW-1:0] prem_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    prem_t                  p_q, p_d;
    logic [WIDTH-1:0]       sh_q, sh_d;
    logic [WIDTH-1:0]       den_q, den_d;
    logic [ITER-1:0]        qr_q, qr_d;
    logic [WIDTH-1:0]       ri_q, ri_d;
    logic [WIDTH-1:0]       quot_q, quot_d;
    logic [WIDTH-1:0]       rem_q, rem_d;
    logic [FRAC_BITS-1:0]   frac_q, frac_d;
    logic                   dz_q, dz_d;
    logic                   done_q, done_d;

    prem_t                  p_nxt;
    logic                   q_bit;
    logic [ITER-1:0]        qr_shift;

    // Numerator bits leave sh_q MSB-first; zeros shift in and feed the fraction iterations.
    div_step #(.WIDTH(WIDTH)) u_step (
        .p_i   (p_q),
        .b_i   (sh_q[WIDTH-1]),
        .den_i (den_q),
        .p_o   (p_nxt),
        .q_o   (q_bit)
    );

    assign qr_shift = {qr_q[ITER-2:0], q_bit};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        sh_d    = sh_q;
        den_d   = den_q;
        qr_d    = qr_q;
        ri_d    = ri_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        frac_d  = frac_q;
        dz_d    = dz_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    den_d = den;
                    sh_d  = num;
                    cnt_d = '0;
                    p_d   = '0;
                    qr_d  = '0;
                    if (den == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        dz_d    = 1'b1;
                        quot_d  = '1;
                        rem_d   = num;
                        frac_d  = '0;
                    end else begin
                        state_d = CALC;
                        dz_d    = 1'b0;
                    end
                end
            end
            CALC: begin
                p_d   = p_nxt;
                sh_d  = sh_q << 1;
                qr_d  = qr_shift;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_INT) begin
                    ri_d = p_nxt[WIDTH-1:0];
                end
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    quot_d  = qr_shift[ITER-1:FRAC_BITS];
                    frac_d  = qr_shift[FRAC_BITS-1:0];
                    rem_d   = ri_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            sh_q    <= '0;
            den_q   <= '0;
            qr_q    <= '0;
            ri_q    <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            frac_q  <= '0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            sh_q    <= sh_d;
            den_q   <= den_d;
            qr_q    <= qr_d;
            ri_q    <= ri_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            frac_q  <= frac_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    assign ready    = (state_q != CALC);
    assign done     = done_q;
    assign quot     = quot_q;
    assign rem      = rem_q;
    assign frac     = frac_q;
    assign div_zero = dz_q;

endmodule
